lsu_sram_requester: RTL
=======================

// Module: lsu_sram_requester
// PURPOSE
// CPU-side initiator for the 32-bit SRAM controller request port (ADDR/WDATA/BMASK/WREN/RDEN -> RDATA/ACK).
// Turns a single-cycle-core LSU access (LB/LH/LW/LBU/LHU/SB/SH/SW) into one strobed controller transaction.
// Stalls the core until ACK, builds byte masks and lane-shifted store data, and sign/zero-extends loads.
// Detects misalignment and ACK timeout.
// PARAMETERS
// TIMEOUT_CYCLES  255  cycles in REQ+WAIT without i_ACK before abort (counter width $clog2(TIMEOUT_CYCLES+1))
// ADDR_LSB        2    lowest LSU address bit mapped to o_ADDR[0]
// PORTS
// i_clk          in   1   clock
// i_reset        in   1   asynchronous, active-low reset
// i_lsu_addr     in   32  byte address from core
// i_lsu_wdata    in   32  store data, right-justified
// i_lsu_wren     in   1   store request (level, held while o_stall)
// i_lsu_rden     in   1   load request (level, held while o_stall)
// i_lsu_funct3   in   3   000 B, 001 H, 010 W, 100 BU, 101 HU
// o_lsu_rdata    out  32  extended load data, valid with o_lsu_valid
// o_lsu_valid    out  1   1-cycle completion pulse (DONE state)
// o_stall        out  1   freeze core PC/pipeline
// o_misaligned   out  1   comb: LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]!=0
// o_timeout      out  1   1-cycle pulse with o_lsu_valid on aborted access
// o_ADDR         out  18  i_lsu_addr[ADDR_LSB+17:ADDR_LSB], registered
// o_WDATA        out  32  lane-replicated store data, registered
// o_BMASK        out  4   byte enables, registered
// o_WREN         out  1   1-cycle write strobe
// o_RDEN         out  1   1-cycle read strobe
// i_RDATA        in   32  controller read word, valid when i_ACK=1
// i_ACK          in   1   controller completion
// BEHAVIOUR
// Reset: state IDLE, all outputs 0, timeout counter 0; reset mid-transaction drops strobes, abandons ACK.
// FSM IDLE -> REQ -> WAIT -> DONE -> IDLE.
// IDLE: if (wren|rden) and aligned: o_stall=1 comb, register o_ADDR/o_WDATA/o_BMASK, latch funct3/addr[1:0]/dir, go REQ.
//   Misaligned: no transaction, no stall, o_misaligned=1, stay IDLE. wren&rden both 1: store wins.
// REQ: exactly one of o_WREN/o_RDEN =1 for this single cycle; o_stall=1; i_ACK sampled; ACK -> DONE else WAIT.
// WAIT: strobes 0, address/data/mask held stable; o_stall=1; i_ACK -> capture i_RDATA, go DONE.
//   Counter increments each REQ/WAIT cycle; reaching TIMEOUT_CYCLES -> DONE with o_timeout=1, rdata=0.
// DONE: o_stall=0, o_lsu_valid=1; core advances this edge; inputs ignored; go IDLE unconditionally.
// Min stall 2 cycles (ACK in REQ); load latency request -> valid = 2 + controller ACK delay.
// i_ACK outside REQ/WAIT ignored.
// Store mask: SB 4'b0001<<a[1:0]; SH 4'b0011<<{a[1],1'b0}; SW 4'b1111.
//   Data: SB {4{b}}, SH {2{h}}, SW word.
// Load: BMASK=4'b1111; byte=RDATA[8*a[1:0]+:8], half=RDATA[16*a[1]+:16]; sign-extend B/H, zero BU/HU.
// Undefined funct3 codes are treated as W.
// o_lsu_rdata registered on ACK, held until next ACK; stores leave it unchanged.
// STRUCTURE
// lsu_sram_pkg: state_e {IDLE,REQ,WAIT,DONE}, funct3 localparams (F3_B/H/W/BU/HU), lane helper functions.
// Sub-module lsu_lane_align: combinational store mask/replication and load extract/extend; FSM and counter stay in top.
// TESTING
// SW 0x00000010 data 0x12345678, ACK 3 cycles after REQ -> one o_WREN pulse, o_ADDR=0x4, BMASK=1111, stall 5 cycles, valid 1 cycle.
// LB 0x00000013, RDATA=0x80FF7F01 -> BMASK=1111, o_lsu_rdata=0xFFFFFF80; LBU same -> 0x00000080.
// SH 0x00000022 data 0x0000BEEF -> BMASK=1100, WDATA=0xBEEFBEEF; LH 0x21 -> o_misaligned=1, no strobe, no stall.
// LW, ACK held in REQ cycle -> stall exactly 2 cycles; ACK never asserted -> o_timeout+valid at cycle 255, rdata=0.
// Reset low during WAIT, late i_ACK -> outputs 0, state IDLE, no o_lsu_valid; wren&rden together -> o_WREN only.

Source files
------------

// File: rtl/lsu_sram_requester_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lsu_sram_pkg
// Purpose  : Shared types and lane helpers for the LSU -> SRAM requester.
//            Holds the FSM state encoding, the LSU funct3 codes, and the
//            byte-lane functions shared by the lane aligner.
// Revision : 1.0  initial release
// ============================================================================
package lsu_sram_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Access width classes; any funct3 outside B/H/BU/HU behaves as a word.
    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    function automatic logic [1:0] f_size(input logic [2:0] funct3);
        logic [1:0] size;
        case (funct3)
            F3_B, F3_BU: size = SZ_B;
            F3_H, F3_HU: size = SZ_H;
            default:     size = SZ_W;
        endcase
        return size;
    endfunction

    function automatic logic f_misaligned(input logic [2:0] funct3,
                                          input logic [1:0] addr_lo);
        logic mis;
        case (f_size(funct3))
            SZ_B:    mis = 1'b0;
            SZ_H:    mis = addr_lo[0];
            default: mis = |addr_lo;
        endcase
        return mis;
    endfunction

    function automatic logic [3:0] f_store_mask(input logic [2:0] funct3,
                                                input logic [1:0] addr_lo);
        logic [3:0] mask;
        case (f_size(funct3))
            SZ_B:    mask = 4'b0001 << addr_lo;
            SZ_H:    mask = 4'b0011 << {addr_lo[1], 1'b0};
            default: mask = 4'b1111;
        endcase
        return mask;
    endfunction

    // Replicating the operand across every lane lets the byte mask alone
    // select which lanes the controller actually writes.
    function automatic logic [31:0] f_store_data(input logic [2:0]  funct3,
                                                 input logic [31:0] wdata);
        logic [31:0] data;
        case (f_size(funct3))
            SZ_B:    data = {4{wdata[7:0]}};
            SZ_H:    data = {2{wdata[15:0]}};
            default: data = wdata;
        endcase
        return data;
    endfunction

    function automatic logic [31:0] f_load_extend(input logic [2:0]  funct3,
                                                  input logic [1:0]  addr_lo,
                                                  input logic [31:0] word);
        logic [31:0] byte_sh;
        logic [31:0] half_sh;
        logic [31:0] data;
        byte_sh = word >> {addr_lo, 3'b000};
        half_sh = word >> {addr_lo[1], 4'b0000};
        case (funct3)
            F3_B:    data = {{24{byte_sh[7]}}, byte_sh[7:0]};
            F3_BU:   data = {24'h000000, byte_sh[7:0]};
            F3_H:    data = {{16{half_sh[15]}}, half_sh[15:0]};
            F3_HU:   data = {16'h0000, half_sh[15:0]};
            default: data = word;
        endcase
        return data;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_sram_requester_if.sv
`default_nettype none
// ============================================================================
// Module   : lsu_sram_requester_if
// Purpose  : Request port of the 32-bit SRAM controller.
//            Signal names are from the requester's point of view.
//   o_ADDR  [17:0]  word address          o_WREN  1  one-cycle write strobe
//   o_WDATA [31:0]  lane-replicated data  o_RDEN  1  one-cycle read strobe
//   o_BMASK [3:0]   byte enables          i_RDATA 32 read word, valid with ACK
//                                         i_ACK   1  transaction complete
// Revision : 1.0  initial release
// ============================================================================
interface lsu_sram_requester_if;
    logic [17:0] o_ADDR;
    logic [31:0] o_WDATA;
    logic [3:0]  o_BMASK;
    logic        o_WREN;
    logic        o_RDEN;
    logic [31:0] i_RDATA;
    logic        i_ACK;

    modport master (
        output o_ADDR, o_WDATA, o_BMASK, o_WREN, o_RDEN,
        input  i_RDATA, i_ACK
    );

    modport slave (
        input  o_ADDR, o_WDATA, o_BMASK, o_WREN, o_RDEN,
        output i_RDATA, i_ACK
    );
endinterface
`default_nettype wire

// File: rtl/lsu_sram_requester_lane_align.sv
`default_nettype none
// ============================================================================
// Module   : lsu_lane_align
// Purpose  : Combinational byte-lane logic for the requester.
//            Store side works on the live LSU request; load side works on
//            the funct3/offset latched at request time.
//   i_st_funct3/i_st_addr_lo/i_st_wdata -> o_st_mask, o_st_wdata,
//                                          o_misaligned_raw
//   i_ld_funct3/i_ld_addr_lo/i_ld_word  -> o_ld_data (extended load)
// Revision : 1.0  initial release
// ============================================================================
module lsu_lane_align
    import lsu_sram_pkg::*;
(
    input  wire logic [2:0]  i_st_funct3,
    input  wire logic [1:0]  i_st_addr_lo,
    input  wire logic [31:0] i_st_wdata,
    output      logic [3:0]  o_st_mask,
    output      logic [31:0] o_st_wdata,
    output      logic        o_misaligned_raw,
    input  wire logic [2:0]  i_ld_funct3,
    input  wire logic [1:0]  i_ld_addr_lo,
    input  wire logic [31:0] i_ld_word,
    output      logic [31:0] o_ld_data
);

    assign o_st_mask        = f_store_mask(i_st_funct3, i_st_addr_lo);
    assign o_st_wdata       = f_store_data(i_st_funct3, i_st_wdata);
    assign o_misaligned_raw = f_misaligned(i_st_funct3, i_st_addr_lo);
    assign o_ld_data        = f_load_extend(i_ld_funct3, i_ld_addr_lo, i_ld_word);

endmodule
`default_nettype wire

// File: rtl/lsu_sram_requester.sv
`default_nettype none
// ============================================================================
// Module   : lsu_sram_requester
// Purpose  : Converts one single-cycle-core LSU access into one strobed
//            SRAM controller transaction, stalling the core until ACK or
//            timeout. FSM IDLE -> REQ -> WAIT -> DONE -> IDLE.
//   i_clk, i_reset (async, active low)
//   i_lsu_addr/wdata/wren/rden/funct3 : core request (held while o_stall)
//   o_lsu_rdata  extended load data    o_lsu_valid  1-cycle completion
//   o_stall      freeze core           o_misaligned comb misalign flag
//   o_timeout    1-cycle abort flag    sram         controller request port
// Revision : 1.0  initial release
// ============================================================================
module lsu_sram_requester
    import lsu_sram_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int ADDR_LSB       = 2
)
(
    input  wire logic                 i_clk,
    input  wire logic                 i_reset,
    input  wire logic [31:0]          i_lsu_addr,
    input  wire logic [31:0]          i_lsu_wdata,
    input  wire logic                 i_lsu_wren,
    input  wire logic                 i_lsu_rden,
    input  wire logic [2:0]           i_lsu_funct3,
    output      logic [31:0]          o_lsu_rdata,
    output      logic                 o_lsu_valid,
    output      logic                 o_stall,
    output      logic                 o_misaligned,
    output      logic                 o_timeout,
    lsu_sram_requester_if.master      sram
);

    localparam int             CNT_W     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] C_TIMEOUT = CNT_W'(TIMEOUT_CYCLES);

    state_e             r_state;
    logic [17:0]        r_addr;
    logic [31:0]        r_wdata;
    logic [3:0]         r_bmask;
    logic               r_wren;
    logic               r_rden;
    logic               r_dir_wr;
    logic [2:0]         r_funct3;
    logic [1:0]         r_addr_lo;
    logic               r_stall;
    logic               r_valid;
    logic               r_timeout;
    logic [31:0]        r_rdata;
    logic [CNT_W-1:0]   r_cnt;

    logic               w_req;
    logic               w_mis_raw;
    logic               w_start;
    logic [3:0]         w_st_mask;
    logic [31:0]        w_st_wdata;
    logic [31:0]        w_ld_data;
    logic [CNT_W-1:0]   w_cnt_inc;
    logic               w_expire;
    logic               w_unused_addr;

    lsu_lane_align u_lane_align (
        .i_st_funct3      (i_lsu_funct3),
        .i_st_addr_lo     (i_lsu_addr[1:0]),
        .i_st_wdata       (i_lsu_wdata),
        .o_st_mask        (w_st_mask),
        .o_st_wdata       (w_st_wdata),
        .o_misaligned_raw (w_mis_raw),
        .i_ld_funct3      (r_funct3),
        .i_ld_addr_lo     (r_addr_lo),
        .i_ld_word        (sram.i_RDATA),
        .o_ld_data        (w_ld_data)
    );

    // Only part of the byte address reaches the controller.
    assign w_unused_addr = ^i_lsu_addr;

    assign w_req     = i_lsu_wren | i_lsu_rden;
    assign w_start   = (r_state == IDLE) && w_req && !w_mis_raw;
    assign w_cnt_inc = r_cnt + CNT_W'(1);
    assign w_expire  = (w_cnt_inc == C_TIMEOUT);

    // The stall must rise in the same cycle the core presents the request,
    // so the IDLE term is combinational; REQ/WAIT use the registered copy.
    assign o_stall      = w_start | r_stall;
    assign o_misaligned = (r_state == IDLE) && w_req && w_mis_raw;
    assign o_lsu_valid  = r_valid;
    assign o_timeout    = r_timeout;
    assign o_lsu_rdata  = r_rdata;

    assign sram.o_ADDR  = r_addr;
    assign sram.o_WDATA = r_wdata;
    assign sram.o_BMASK = r_bmask;
    assign sram.o_WREN  = r_wren;
    assign sram.o_RDEN  = r_rden;

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state   <= IDLE;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_bmask   <= '0;
            r_wren    <= 1'b0;
            r_rden    <= 1'b0;
            r_dir_wr  <= 1'b0;
            r_funct3  <= '0;
            r_addr_lo <= '0;
            r_stall   <= 1'b0;
            r_valid   <= 1'b0;
            r_timeout <= 1'b0;
            r_rdata   <= '0;
            r_cnt     <= '0;
        end else begin
            // Strobes and completion flags are single-cycle pulses.
            r_wren    <= 1'b0;
            r_rden    <= 1'b0;
            r_valid   <= 1'b0;
            r_timeout <= 1'b0;

            case (r_state)
                IDLE: begin
                    if (w_start) begin
                        r_addr    <= i_lsu_addr[ADDR_LSB+17:ADDR_LSB];
                        r_wdata   <= w_st_wdata;
                        // Store takes priority when both requests are high.
                        r_bmask   <= i_lsu_wren ? w_st_mask : 4'b1111;
                        r_wren    <= i_lsu_wren;
                        r_rden    <= !i_lsu_wren;
                        r_dir_wr  <= i_lsu_wren;
                        r_funct3  <= i_lsu_funct3;
                        r_addr_lo <= i_lsu_addr[1:0];
                        r_stall   <= 1'b1;
                        r_cnt     <= '0;
                        r_state   <= REQ;
                    end
                end

                REQ, WAIT: begin
                    if (sram.i_ACK) begin
                        if (!r_dir_wr) begin
                            r_rdata <= w_ld_data;
                        end
                        r_stall <= 1'b0;
                        r_valid <= 1'b1;
                        r_cnt   <= '0;
                        r_state <= DONE;
                    end else if (w_expire) begin
                        r_rdata   <= '0;
                        r_stall   <= 1'b0;
                        r_valid   <= 1'b1;
                        r_timeout <= 1'b1;
                        r_cnt     <= '0;
                        r_state   <= DONE;
                    end else begin
                        r_cnt   <= w_cnt_inc;
                        r_state <= WAIT;
                    end
                end

                DONE: begin
                    // The core advances on this edge; its request is ignored.
                    r_state <= IDLE;
                end

                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
